// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register: valid/ready handshake with a one-entry skid buffer,
// store-data lane replication, byte-enable generation and misaligned-store flagging.
module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_memwr,
  input  logic              ex_regwr,
  input  logic              ex_wasel,
  input  logic [1:0]        ex_wbsel,
  input  logic [REG_AW-1:0] ex_rdaddr,
  input  logic [2:0]        ex_func3,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_rs2o,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_memwr,
  output logic              mem_regwr,
  output logic              mem_wasel,
  output logic [1:0]        mem_wbsel,
  output logic [REG_AW-1:0] mem_rdaddr,
  output logic [2:0]        mem_func3,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_misalign
);

  typedef struct packed {
    logic              memwr;
    logic              regwr;
    logic              wasel;
    logic [1:0]        wbsel;
    logic [REG_AW-1:0] rdaddr;
    logic [2:0]        func3;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wmask;
    logic              misalign;
  } entry_t;

  entry_t     in_entry;
  entry_t     main_entry;
  entry_t     skid_entry;
  logic       main_valid;
  logic       skid_valid;
  logic       accept;
  logic       stall;
  logic [1:0] lane;

  assign ex_ready = ~skid_valid;
  assign accept   = ex_valid & ex_ready;
  assign stall    = main_valid & ~mem_ready;
  assign lane     = ex_alu_out[1:0];

  // Store formatting is done once at capture so the MEM stage sees ready-to-use lanes.
  // NOTE: every field gets a default before the case so no path leaves a latch behind.
  always_comb begin
    in_entry          = '0;
    in_entry.memwr    = ex_memwr;
    in_entry.regwr    = ex_regwr;
    in_entry.wasel    = ex_wasel;
    in_entry.wbsel    = ex_wbsel;
    in_entry.rdaddr   = ex_rdaddr;
    in_entry.func3    = ex_func3;
    in_entry.addr     = ex_alu_out;
    in_entry.wdata    = ex_rs2o;
    case (ex_func3[1:0])
      2'b00: begin
        in_entry.wdata = {4{ex_rs2o[7:0]}};
        in_entry.wmask = 4'b0001 << lane;
      end
      2'b01: begin
        in_entry.wdata    = {2{ex_rs2o[15:0]}};
        in_entry.wmask    = lane[1] ? 4'b1100 : 4'b0011;
        in_entry.misalign = lane[0];
      end
      2'b10: begin
        in_entry.wmask    = 4'b1111;
        in_entry.misalign = (lane != 2'b00);
      end
      default: begin
        in_entry.wmask    = 4'b0000;
        in_entry.misalign = 1'b1;
      end
    endcase
    if (!ex_memwr) begin
      in_entry.wmask    = 4'b0000;
      in_entry.misalign = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_entry <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!stall) begin
      if (skid_valid) begin
        main_entry <= skid_entry;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_entry <= in_entry;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: skid payload is not reset; skid_valid alone decides whether it is ever used.
  always_ff @(posedge clk) begin
    if (!flush && stall && accept) begin
      skid_entry <= in_entry;
    end
  end

  assign mem_valid    = main_valid;
  assign mem_memwr    = main_entry.memwr & main_valid & ~main_entry.misalign;
  assign mem_regwr    = main_entry.regwr & main_valid & (main_entry.rdaddr != '0);
  assign mem_misalign = main_entry.misalign & main_valid;
  assign mem_wasel    = main_entry.wasel;
  assign mem_wbsel    = main_entry.wbsel;
  assign mem_rdaddr   = main_entry.rdaddr;
  assign mem_func3    = main_entry.func3;
  assign mem_addr     = main_entry.addr;
  assign mem_wdata    = main_entry.wdata;
  assign mem_wmask    = main_entry.wmask;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: a FIFO of accepted bundles (capacity two) is the
// reference; a negedge monitor compares the MEM side against the head of that FIFO.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_memwr = 1'b0;
  logic        ex_regwr = 1'b0;
  logic        ex_wasel = 1'b0;
  logic [1:0]  ex_wbsel = '0;
  logic [4:0]  ex_rdaddr = '0;
  logic [2:0]  ex_func3 = '0;
  logic [31:0] ex_alu_out = '0;
  logic [31:0] ex_rs2o = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_memwr;
  logic        mem_regwr;
  logic        mem_wasel;
  logic [1:0]  mem_wbsel;
  logic [4:0]  mem_rdaddr;
  logic [2:0]  mem_func3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_misalign;

  ex_mem_reg #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_memwr(ex_memwr), .ex_regwr(ex_regwr), .ex_wasel(ex_wasel),
    .ex_wbsel(ex_wbsel), .ex_rdaddr(ex_rdaddr), .ex_func3(ex_func3),
    .ex_alu_out(ex_alu_out), .ex_rs2o(ex_rs2o),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_memwr(mem_memwr), .mem_regwr(mem_regwr), .mem_wasel(mem_wasel),
    .mem_wbsel(mem_wbsel), .mem_rdaddr(mem_rdaddr), .mem_func3(mem_func3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_misalign(mem_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        memwr;
    bit        regwr;
    bit        wasel;
    bit [1:0]  wbsel;
    bit [4:0]  rdaddr;
    bit [2:0]  func3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [3:0]  wmask;
    bit        misalign;
    bit        check_wdata;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   pend_accept = 1'b0;
  bit   pend_flush = 1'b0;
  exp_t pend_item;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an access of n bytes covers the n lanes of its naturally aligned
  // n-byte block; source byte (lane mod n) lands in each lane.
  function automatic exp_t model();
    exp_t e;
    int   sz;
    int   n;
    int   a;
    int   base;
    e.memwr       = ex_memwr;
    e.regwr       = ex_regwr;
    e.wasel       = ex_wasel;
    e.wbsel       = ex_wbsel;
    e.rdaddr      = ex_rdaddr;
    e.func3       = ex_func3;
    e.addr        = ex_alu_out;
    e.wdata       = ex_rs2o;
    e.wmask       = '0;
    e.misalign    = 1'b0;
    sz            = int'(ex_func3[1:0]);
    a             = int'(ex_alu_out[1:0]);
    e.check_wdata = ex_memwr && (sz != 3);
    if (sz == 3) begin
      e.misalign = ex_memwr;
    end else begin
      n = 1 << sz;
      for (int l = 0; l < 4; l++) e.wdata[l*8 +: 8] = ex_rs2o[(l % n)*8 +: 8];
      if (ex_memwr) begin
        e.misalign = (a % n) != 0;
        base = a - (a % n);
        for (int l = 0; l < 4; l++) e.wmask[l] = (l >= base) && (l < base + n);
      end
    end
    return e;
  endfunction

  task automatic set_bundle(input bit memwr, input bit regwr, input bit [2:0] f3,
                            input bit [31:0] addr, input bit [31:0] rs2, input bit [4:0] rd);
    ex_memwr   = memwr;
    ex_regwr   = regwr;
    ex_func3   = f3;
    ex_alu_out = addr;
    ex_rs2o    = rs2;
    ex_rdaddr  = rd;
    ex_wasel   = 1'($urandom);
    ex_wbsel   = 2'($urandom);
  endtask

  // Drive handshake inputs for the coming edge and record what the model expects it to do.
  task automatic apply(input bit v, input bit rdy, input bit fl);
    ex_valid    = v;
    mem_ready   = rdy;
    flush       = fl;
    pend_flush  = fl;
    pend_accept = v && (q.size() < 2);
    pend_item   = model();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      if (pend_flush) q.delete();
      else if (pend_accept) q.push_back(pend_item);
    end
  endtask

  // Monitor: compares outputs with the oldest held bundle, retires it when MEM consumes.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst_mem_valid", mem_valid, 0);
        check("rst_ex_ready", ex_ready, 1);
        check("rst_mem_memwr", mem_memwr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wmask", mem_wmask, 0);
      end else begin
        check("mem_valid", mem_valid, q.size() > 0);
        check("ex_ready", ex_ready, q.size() < 2);
        if (q.size() > 0) begin
          exp_t e;
          e = q[0];
          check("mem_memwr", mem_memwr, e.memwr && !e.misalign);
          check("mem_regwr", mem_regwr, e.regwr && (e.rdaddr != 0));
          check("mem_misalign", mem_misalign, e.misalign);
          check("mem_wasel", mem_wasel, e.wasel);
          check("mem_wbsel", mem_wbsel, e.wbsel);
          check("mem_rdaddr", mem_rdaddr, e.rdaddr);
          check("mem_func3", mem_func3, e.func3);
          check("mem_addr", mem_addr, e.addr);
          check("mem_wmask", mem_wmask, e.wmask);
          if (e.check_wdata) check("mem_wdata", mem_wdata, e.wdata);
          if (mem_ready && !flush) void'(q.pop_front());
        end else begin
          check("idle_memwr", mem_memwr, 0);
          check("idle_regwr", mem_regwr, 0);
          check("idle_misalign", mem_misalign, 0);
        end
      end
    end
  end

  initial begin
    apply(0, 1, 0);
    tick();
    tick();
    rst = 1'b1;

    // Aligned word store, then byte store at lane 3.
    set_bundle(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0);
    apply(1, 1, 0);
    tick();
    apply(0, 1, 0);
    @(negedge clk);
    check("t1_valid", mem_valid, 1);
    check("t1_memwr", mem_memwr, 1);
    check("t1_wmask", mem_wmask, 4'b1111);
    check("t1_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    set_bundle(1, 0, 3'b000, 32'h103, 32'h000000A5, 0);
    apply(1, 1, 0);
    tick();
    apply(0, 1, 0);
    @(negedge clk);
    check("t2_wdata", mem_wdata, 32'hA5A5A5A5);
    check("t2_wmask", mem_wmask, 4'b1000);
    check("t2_misalign", mem_misalign, 0);
    tick();

    // Misaligned half and word stores.
    set_bundle(1, 0, 3'b001, 32'h201, 32'h1234, 0);
    apply(1, 1, 0);
    tick();
    set_bundle(1, 0, 3'b010, 32'h202, 32'h55AA55AA, 0);
    apply(1, 1, 0);
    @(negedge clk);
    check("t3h_misalign", mem_misalign, 1);
    check("t3h_memwr", mem_memwr, 0);
    check("t3h_wmask", mem_wmask, 4'b0011);
    tick();
    apply(0, 1, 0);
    @(negedge clk);
    check("t3w_misalign", mem_misalign, 1);
    check("t3w_wmask", mem_wmask, 4'b1111);
    tick();

    // Stall with skid capture, then drain in order: A, B, C.
    set_bundle(1, 1, 3'b010, 32'hA00, 32'hAAAA0000, 1);
    apply(1, 1, 0);
    tick();
    set_bundle(1, 1, 3'b010, 32'hB00, 32'hBBBB0000, 2);
    apply(1, 0, 0);
    tick();
    set_bundle(1, 1, 3'b010, 32'hC00, 32'hCCCC0000, 3);
    apply(1, 1, 0);
    @(negedge clk);
    check("t4_skid_ready", ex_ready, 0);
    check("t4_hold_addr", mem_addr, 32'hA00);
    tick();
    apply(1, 1, 0);
    @(negedge clk);
    check("t4_b_addr", mem_addr, 32'hB00);
    tick();
    apply(0, 1, 0);
    @(negedge clk);
    check("t4_c_addr", mem_addr, 32'hC00);
    tick();

    // Flush with both slots full and a same-cycle offer.
    set_bundle(1, 1, 3'b010, 32'hA10, 32'h1, 4);
    apply(1, 1, 0);
    tick();
    set_bundle(1, 1, 3'b010, 32'hB10, 32'h2, 5);
    apply(1, 0, 0);
    tick();
    set_bundle(1, 1, 3'b010, 32'hC10, 32'h3, 6);
    apply(1, 0, 1);
    tick();
    apply(0, 1, 0);
    @(negedge clk);
    check("t5_valid", mem_valid, 0);
    check("t5_ready", ex_ready, 1);
    check("t5_memwr", mem_memwr, 0);
    tick();

    // Register write gating on x0.
    set_bundle(0, 1, 3'b010, 32'h300, 32'h0, 0);
    apply(1, 1, 0);
    tick();
    set_bundle(0, 1, 3'b010, 32'h304, 32'h0, 5);
    apply(1, 1, 0);
    @(negedge clk);
    check("t6_regwr_x0", mem_regwr, 0);
    tick();
    apply(0, 1, 0);
    @(negedge clk);
    check("t6_regwr_x5", mem_regwr, 1);
    tick();

    // Asynchronous reset in the middle of a stall with both slots full.
    set_bundle(1, 1, 3'b010, 32'h400, 32'h4, 7);
    apply(1, 0, 0);
    tick();
    set_bundle(1, 1, 3'b010, 32'h404, 32'h5, 8);
    apply(1, 0, 0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", mem_valid, 0);
    q.delete();
    apply(0, 1, 0);
    tick();
    rst = 1'b1;
    apply(0, 1, 0);
    tick();
    tick();

    // Randomized traffic with random stalls and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      bit [31:0] addr;
      addr = {$urandom_range(0, 255), 2'($urandom)};
      set_bundle(1'($urandom), 1'($urandom), 3'($urandom), addr, $urandom,
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      tick();
    end

    apply(0, 1, 0);
    repeat (4) tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the EX and MEM stages; consumes the EX-stage control and operand bundle plus the ALU result.
- Uses a valid/ready handshake with a one-entry skid buffer, so a MEM-side stall never drops an instruction that EX launched in the same cycle.
- Pre-formats store data and the byte-enable mask.
- Flags misaligned stores and suppresses their write.

Parameters:
- DATA_W, 32, datapath width (only 32 supported by store formatting).
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- ex_valid  in  1  EX bundle valid this cycle.
- ex_ready  out  1  register can accept the EX bundle this cycle.
- ex_memwr  in  1  store instruction.
- ex_regwr  in  1  writes the register file.
- ex_wasel  in  1  writeback address select.
- ex_wbsel  in  2  writeback mux select.
- ex_rdaddr  in  REG_AW  destination register.
- ex_func3  in  3  instruction func3 (access size).
- ex_alu_out  in  DATA_W  ALU result / memory address.
- ex_rs2o  in  DATA_W  store source data.
- mem_valid  out  1  MEM bundle valid.
- mem_ready  in  1  MEM stage consumes the bundle this cycle (low = stall).
- mem_memwr  out  1  gated store strobe.
- mem_regwr  out  1  gated register write.
- mem_wasel  out  1  registered copy of ex_wasel.
- mem_wbsel  out  2  registered copy of ex_wbsel.
- mem_rdaddr  out  REG_AW  registered copy of ex_rdaddr.
- mem_func3  out  3  registered copy of ex_func3.
- mem_addr  out  DATA_W  registered ALU result.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_wmask  out  4  byte enables.
- mem_misalign  out  1  misaligned or illegal-size store.

Behaviour:
- Reset (rst=0, async):
  - main_valid=0, skid_valid=0.
  - All mem_* outputs 0; ex_ready=1 after release.
- ex_ready is a registered signal equal to !skid_valid. An accept occurs when ex_valid & ex_ready.
- Edge update, when main_valid=0 or mem_ready=1 (main slot free or draining):
  - If skid_valid: main<=skid, skid_valid<=0.
  - Else if accept: main<=EX bundle, main_valid<=1.
  - Else: main_valid<=0.
- Edge update, when main_valid=1 and mem_ready=0 (stall):
  - Main holds.
  - If accept: skid<=EX bundle, skid_valid<=1.
- Latency and ordering:
  - Latency EX→MEM is 1 cycle when unstalled.
  - Order is preserved; the skid entry always precedes new input.
  - After the skid drains, ex_ready returns to 1 on the following cycle.
- flush=1 at an edge:
  - main_valid<=0, skid_valid<=0.
  - Any same-cycle accept is discarded.
  - Has priority over the handshake; rst has priority over flush.
- Store formatting, computed at capture on the incoming bundle and stored per entry. a = ex_alu_out[1:0]:
  - func3[1:0]=00 (byte): wdata={4{rs2o[7:0]}}, mask=0001<<a, never misaligned.
  - func3[1:0]=01 (half): wdata={2{rs2o[15:0]}}, mask=a[1]?1100:0011, misaligned if a[0].
  - func3[1:0]=10 (word): wdata=rs2o, mask=1111, misaligned if a!=0.
  - func3[1:0]=11: mask=0000, misaligned=1.
  - If memwr=0: mask=0000, misaligned=0.
- Output gating (combinational on the main slot):
  - mem_memwr = memwr & main_valid & !misalign.
  - mem_regwr = regwr & main_valid & (rdaddr!=0).
  - mem_misalign = misalign & main_valid.
- Data outputs (addr, wdata, rdaddr, …) hold their last value when invalid; they are not cleared by flush.
- Reset mid-stall: both entries are lost; no store strobe occurs after reset release until a new accept.

Test Plan:
1. Reset, then ex_valid=1, mem_ready=1, alu_out=0x100, rs2o=0xDEADBEEF, func3=010, memwr=1 → next cycle mem_valid=1, mem_memwr=1, wmask=1111, wdata=0xDEADBEEF.
2. Byte store, alu_out=0x103, rs2o=0x000000A5, func3=000 → wdata=0xA5A5A5A5, wmask=1000, misalign=0.
3. Half store at alu_out=0x201 → mem_misalign=1, mem_memwr=0, wmask=0011; word store at 0x202 → misalign=1, wmask=1111.
4. Main holds A, mem_ready=0, ex_valid=1 with B → B in skid, ex_ready=0 next cycle, mem outputs still A. Raise mem_ready → B presented the next cycle, ex_ready=1 one cycle later, then C.
5. Main=A, skid=B, flush=1 with ex_valid=1 (C) → next cycle mem_valid=0, ex_ready=1, no memwr/regwr strobes, C discarded.
6. regwr=1, rdaddr=0 → mem_regwr=0; rdaddr=5 → mem_regwr=1. Pulling rst low mid-stall → mem_valid=0 immediately (asynchronously).
